// File: rtl/input_k_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : input_k_sequencer
// Brief    : Sequences inference runs of the NN core. Drives the input-k
//            generator selector from debounced switches (manual) or a 0..7
//            scan (auto), launches the core with latched (k1, k2), waits for
//            completion with a timeout, then captures and classifies the result.
// Revision : 1.0 - initial release
// ============================================================================
module input_k_sequencer #(
    parameter int DB_CYCLES      = 1000000,
    parameter int DWELL_CYCLES   = 50000000,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  sw,
    input  logic        auto_mode,
    output logic [3:0]  sel,
    input  logic [15:0] gen_k1,
    input  logic [15:0] gen_k2,
    output logic [15:0] k1,
    output logic [15:0] k2,
    output logic        nn_start,
    input  logic        nn_done,
    input  logic [15:0] nn_result,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        class_out,
    output logic        timeout_err,
    output logic        busy
);

    localparam logic [31:0] c_DB_LAST    = 32'(DB_CYCLES - 1);
    localparam logic [31:0] c_DWELL_LAST = 32'(DWELL_CYCLES - 1);
    localparam logic [31:0] c_TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] c_SETTLE_LAST = 32'd1;
    localparam logic [15:0] c_CLASS_THR  = 16'h0200;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_DWELL   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_sw_meta;
    logic [3:0]  r_sw_sync;
    logic [3:0]  r_sw_cand;
    logic [3:0]  r_sw_stable;
    logic        r_sw_event;
    logic [31:0] r_db_cnt;

    logic [31:0] r_cnt;
    logic        r_auto;
    logic [2:0]  r_scan;
    logic [3:0]  r_sel;
    logic [15:0] r_k1;
    logic [15:0] r_k2;
    logic [15:0] r_result;
    logic        r_result_valid;
    logic        r_class;
    logic        r_timeout_err;
    logic        r_busy;

    logic        w_launch;
    logic        w_capture;
    logic        w_timeout;
    logic        w_dwell_done;

    // Two-flop synchronizer for the asynchronous slide switches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_meta <= 4'd0;
            r_sw_sync <= 4'd0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Debouncer: candidate must hold DB_CYCLES cycles before becoming stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_cand   <= 4'd0;
            r_sw_stable <= 4'd0;
            r_sw_event  <= 1'b0;
            r_db_cnt    <= 32'd0;
        end else if (r_sw_sync != r_sw_cand) begin
            r_sw_cand  <= r_sw_sync;
            r_db_cnt   <= 32'd0;
            r_sw_event <= 1'b0;
        end else if (r_db_cnt == c_DB_LAST) begin
            r_sw_event  <= (r_sw_stable != r_sw_cand);
            r_sw_stable <= r_sw_cand;
        end else begin
            r_db_cnt   <= r_db_cnt + 32'd1;
            r_sw_event <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and single-cycle strobes; nn_start decoded from state
    // so an asynchronous reset removes it immediately
    always_comb begin
        w_state_nxt  = r_state;
        w_launch     = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_dwell_done = 1'b0;
        nn_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (auto_mode || r_sw_event) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                nn_start    = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // completion wins over a timeout expiring in the same cycle
                if (nn_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_CAPTURE;
                end else if (r_cnt == c_TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = r_auto ? S_DWELL : S_IDLE;
                end
            end
            S_CAPTURE: begin
                w_state_nxt = r_auto ? S_DWELL : S_IDLE;
            end
            S_DWELL: begin
                if (!auto_mode) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_DWELL_LAST) begin
                    w_dwell_done = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Shared state timer: restarts on every state change, idle in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 32'd0;
        end else if ((r_state != w_state_nxt) || (r_state == S_IDLE)) begin
            r_cnt <= 32'd0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // Run datapath: selector, operand latch, result capture and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auto         <= 1'b0;
            r_scan         <= 3'd0;
            r_sel          <= 4'd0;
            r_k1           <= 16'd0;
            r_k2           <= 16'd0;
            r_result       <= 16'd0;
            r_result_valid <= 1'b0;
            r_class        <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_busy         <= (w_state_nxt != S_IDLE);
            if (w_launch) begin
                r_auto <= auto_mode;
                r_sel  <= auto_mode ? {1'b0, r_scan} : r_sw_stable;
            end
            if (r_state == S_START) begin
                r_k1 <= gen_k1;
                r_k2 <= gen_k2;
            end
            if (w_capture) begin
                r_result       <= nn_result;
                r_class        <= (nn_result >= c_CLASS_THR);
                r_result_valid <= 1'b1;
                r_timeout_err  <= 1'b0;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            if (w_dwell_done) begin
                r_scan <= r_scan + 3'd1;
            end
        end
    end

    assign sel          = r_sel;
    assign k1           = r_k1;
    assign k2           = r_k2;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign class_out    = r_class;
    assign timeout_err  = r_timeout_err;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: doc/input_k_sequencer.md
# input_k_sequencer

Control block that sequences board-level inference runs of the neural-network core. It drives the 4-bit selector of the input-k generator, lets the generator's registered outputs settle, launches the core with a latched (k1, k2) pair, and waits for completion with a timeout. It then captures and classifies the 16-bit result. It runs in one of two modes: manual, where one run is started on each debounced slide-switch change, or auto, where selectors 0..7 are scanned cyclically with a dwell between runs.

## Interface
- DB_CYCLES, 1000000: consecutive stable cycles required to accept a new switch value.
- DWELL_CYCLES, 50000000: idle cycles between runs in auto mode.
- TIMEOUT_CYCLES, 1024: maximum cycles to wait for nn_done after nn_start.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sw  in  4  raw slide switches; asynchronous to clk.
- auto_mode  in  1  1 = scan selectors 0..7; 0 = manual. Sampled only in IDLE.
- sel  out  4  selector to the input-k generator.
- gen_k1, gen_k2  in  16 each  generator outputs, unsigned, 10 fractional bits; valid 1 cycle after sel changes.
- k1, k2  out  16 each  latched operands to the core; held stable from START until the next START.
- nn_start  out  1  single-cycle launch pulse.
- nn_done  in  1  core completion; may be a level or a pulse.
- nn_result  in  16  core output; valid in the cycle nn_done is 1.
- result  out  16  captured nn_result.
- result_valid  out  1  single-cycle pulse when result updates.
- class_out  out  1  1 when result >= 16'h0200 (0.5); updated together with result.
- timeout_err  out  1  sticky; set on timeout, cleared by the next successful capture or by reset.
- busy  out  1  1 in every state except IDLE.

## Operation
- Input synchronizer: sw passes through a 2-flop synchronizer, then the debouncer.
- Debouncer: a counter restarts whenever the synchronized value differs from the candidate value.
  - On reaching DB_CYCLES-1 with no difference, the candidate becomes sw_stable.
  - Any change of sw_stable raises a one-cycle sw_event.
- FSM states: IDLE, SETTLE, START, WAIT, CAPTURE, DWELL.
- IDLE:
  - Manual: on sw_event, sel <= sw_stable; go to SETTLE.
  - Auto: sel <= scan index, starting at 0 after reset; go to SETTLE.
- SETTLE: 2 cycles (covers generator register plus margin); go to START.
- START:
  - k1 <= gen_k1, k2 <= gen_k2.
  - nn_start = 1 for exactly this cycle.
  - Clear timeout counter; go to WAIT.
- WAIT:
  - If nn_done, go to CAPTURE.
  - Else, if the counter reaches TIMEOUT_CYCLES-1, set timeout_err and go to DWELL (auto) or IDLE (manual).
  - nn_done in the same cycle the counter expires counts as success.
- CAPTURE:
  - result <= nn_result latched in the WAIT cycle that saw nn_done.
  - Compute class_out; pulse result_valid; clear timeout_err.
  - Go to DWELL (auto) or IDLE (manual).
- DWELL:
  - Count DWELL_CYCLES.
  - At expiry, scan index increments, wrapping 7 -> 0, then go to IDLE.
  - auto_mode dropping to 0 during DWELL aborts it immediately to IDLE; the index does not increment.
- Manual sw_event arriving while busy is discarded. After returning to IDLE, a new run needs a new event.
- Selectors 8..15 are legal in manual mode; the generator returns 0, and the run proceeds normally.
- Comparison for class_out is unsigned.

## Timing
- Reset values:
  - sel = 0, k1 = k2 = 0, result = 0.
  - nn_start = result_valid = class_out = timeout_err = busy = 0.
  - FSM = IDLE; scan index = 0; debouncer candidate = sw_stable = 0; counters = 0.
- Reset asserted mid-run drops nn_start immediately. Any in-flight nn_done is ignored after release.
- nn_start latency:
  - Manual: 3 cycles after sw_event (IDLE -> SETTLE x2 -> START).
  - Auto: 3 cycles after leaving IDLE.
- result_valid comes 1 cycle after the WAIT cycle that sees nn_done.
- busy is registered; it rises on the cycle after IDLE is left and falls on the cycle IDLE is re-entered.
- Auto period per vector = 3 + core latency + 1 + DWELL_CYCLES + 1 cycles.

## Test plan
- Manual run: DB_CYCLES=4, sw=4'b0010 held stable, core returns done after 5 cycles with nn_result=16'h0300 -> sel=2, nn_start pulses once with k1=16'h1400, k2=16'h2000; result=16'h0300, class_out=1, one result_valid pulse.
- Bounce rejection: sw toggles 0010/0011 every 2 cycles for 20 cycles, then holds 0011 -> exactly one run, sel=3, k1=k2=16'h1400.
- Auto scan: DWELL_CYCLES=8, core echoes nn_result=16'h0100 -> sel visits 0..7 then 0 again; 8 result_valid pulses per lap, all with class_out=0.
- Timeout: TIMEOUT_CYCLES=16, nn_done never asserted -> timeout_err set 16 cycles after nn_start, no result_valid; next successful run clears timeout_err.
- Boundary: nn_done in the same cycle as timeout expiry -> success, timeout_err stays 0. auto_mode deasserted mid-DWELL -> IDLE next cycle, scan index unchanged.
- Reset in WAIT: rst_n low for 1 cycle, then nn_done pulses -> all outputs at reset values, no result_valid.
